wb_trace_unit: RTL and testbench

- Retirement-trace reader for the multi-cycle ARM core: snoops the core's writeback and store signals, records every register write and memory write as a trace record, and drains the records over a valid/ready stream.
- It is the in-silicon counterpart of the simulation observer. It sits beside `top`, connects to the same visualiser nets (RegWrite, Rd, Ra, Result, IsLongMul, MemWrite, Adr, WriteData), and feeds a debug port or logger.

---
 rtl/trace_pkg.sv | 27 ++
 rtl/trace_fifo.sv | 61 ++++++
 rtl/wb_trace_unit.sv | 153 +++++++++++++++
 tb/tb_wb_trace_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared record kinds, record width and drop-FSM encodings.
// Revision : 1.0
// ============================================================================
package trace_pkg;

    localparam logic [1:0] TK_REG   = 2'd0;
    localparam logic [1:0] TK_MEM   = 2'd1;
    localparam logic [1:0] TK_REGHI = 2'd2;

    localparam int SEQ_W_DEFAULT = 16;
    localparam int REC_W         = 2 + 32 + 32 + SEQ_W_DEFAULT;

    // Record width for an arbitrary sequence-number width.
    function automatic int rec_width(input int seq_w);
        return 2 + 32 + 32 + seq_w;
    endfunction

    typedef enum logic [0:0] {
        ST_OK   = 1'b0,
        ST_LOSS = 1'b1
    } drop_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Brief    : Show-ahead FIFO accepting 0-3 pushes and one pop per cycle.
// Revision : 1.0
// ============================================================================
module trace_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [1:0]       i_push_n,
    input  logic [W-1:0]     i_din0,
    input  logic [W-1:0]     i_din1,
    input  logic [W-1:0]     i_din2,
    input  logic             i_pop,
    output logic [W-1:0]     o_dout,
    output logic [PTR_W:0]   o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr1;
    logic [PTR_W-1:0] w_wr_ptr2;

    assign w_pop     = i_pop && (r_count != '0);
    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    assign w_wr_ptr2 = r_wr_ptr + PTR_W'(2);

    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + (PTR_W+1)'(i_push_n) - (PTR_W+1)'(w_pop);
        end
    end

    // Storage is not reset; the top gates outputs while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset && !i_flush) begin
            if (i_push_n >= 2'd1) r_mem[r_wr_ptr]  <= i_din0;
            if (i_push_n >= 2'd2) r_mem[w_wr_ptr1] <= i_din1;
            if (i_push_n == 2'd3) r_mem[w_wr_ptr2] <= i_din2;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_unit
// Brief    : Captures core register/memory writes as sequenced trace records.
// Revision : 1.0
// ============================================================================
module wb_trace_unit
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trace_en,
    input  logic             flush,
    input  logic             RegWrite,
    input  logic [3:0]       Rd,
    input  logic [3:0]       Ra,
    input  logic [31:0]      Result,
    input  logic [31:0]      ResultHi,
    input  logic             IsLongMul,
    input  logic             MemWrite,
    input  logic [31:0]      Adr,
    input  logic [31:0]      WriteData,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [1:0]       trace_kind,
    output logic [31:0]      trace_tag,
    output logic [31:0]      trace_data,
    output logic [SEQ_W-1:0] trace_seq,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int             W_REC     = rec_width(SEQ_W);
    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic             w_mem_ev;
    logic             w_reg_ev;
    logic             w_hi_ev;
    logic [1:0]       w_n;
    logic [PTR_W:0]   w_count;
    logic [PTR_W:0]   w_free;
    logic             w_fits;
    logic             w_accept;
    logic             w_drop;
    logic [1:0]       w_push_n;
    logic             w_pop;
    logic [W_REC-1:0] w_din0;
    logic [W_REC-1:0] w_din1;
    logic [W_REC-1:0] w_din2;
    logic [W_REC-1:0] w_dout;
    logic [SEQ_W-1:0] w_seq1;
    logic [SEQ_W-1:0] w_seq2;

    logic [SEQ_W-1:0] r_seq;
    logic             r_overflow;
    logic [15:0]      r_drop_cnt;
    drop_state_t      r_state;
    drop_state_t      w_state_nxt;
    logic             w_drop_inc;

    assign w_mem_ev = trace_en & MemWrite;
    assign w_reg_ev = trace_en & RegWrite;
    assign w_hi_ev  = w_reg_ev & IsLongMul;
    assign w_n      = {1'b0, w_mem_ev} + {1'b0, w_reg_ev} + {1'b0, w_hi_ev};

    // Free space is judged on the start-of-cycle count; a same-cycle pop gives no credit.
    assign w_free   = DEPTH_CNT - w_count;
    assign w_fits   = w_free >= (PTR_W+1)'(w_n);
    assign w_accept = !flush && w_fits;
    assign w_drop   = !flush && !w_fits;
    assign w_push_n = w_accept ? w_n : 2'd0;
    assign w_pop    = trace_valid & trace_ready;

    assign w_seq1 = r_seq + SEQ_W'(1);
    assign w_seq2 = r_seq + SEQ_W'(2);

    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        w_din2 = '0;
        if (w_mem_ev) begin
            w_din0 = {TK_MEM,   Adr,          WriteData, r_seq};
            w_din1 = {TK_REG,   {28'd0, Rd},  Result,    w_seq1};
            w_din2 = {TK_REGHI, {28'd0, Ra},  ResultHi,  w_seq2};
        end else begin
            w_din0 = {TK_REG,   {28'd0, Rd},  Result,    r_seq};
            w_din1 = {TK_REGHI, {28'd0, Ra},  ResultHi,  w_seq1};
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (W_REC)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (flush),
        .i_push_n (w_push_n),
        .i_din0   (w_din0),
        .i_din1   (w_din1),
        .i_din2   (w_din2),
        .i_pop    (w_pop),
        .o_dout   (w_dout),
        .o_count  (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seq <= '0;
        end else begin
            r_seq <= r_seq + SEQ_W'(w_push_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_OK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop_inc  = w_drop && (r_drop_cnt != 16'hFFFF);
        unique case (r_state)
            ST_OK:   if (w_drop) w_state_nxt = ST_LOSS;
            ST_LOSS: if (w_accept && (w_n != 2'd0)) w_state_nxt = ST_OK;
            default: w_state_nxt = ST_OK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop)     r_overflow <= 1'b1;
            if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign trace_valid = (w_count != '0);
    assign {trace_kind, trace_tag, trace_data, trace_seq} = trace_valid ? w_dout : '0;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_trace_unit
// Brief    : Randomised and directed checks of wb_trace_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_wb_trace_unit;

    localparam int DEPTH = 16;
    localparam int SEQ_W = 4;

    logic             clk = 1'b0;
    logic             reset, trace_en, flush, RegWrite, IsLongMul, MemWrite, trace_ready;
    logic [3:0]       Rd, Ra;
    logic [31:0]      Result, ResultHi, Adr, WriteData;
    logic             trace_valid, overflow;
    logic [1:0]       trace_kind;
    logic [31:0]      trace_tag, trace_data;
    logic [SEQ_W-1:0] trace_seq;
    logic [15:0]      drop_cnt;

    always #5 clk = ~clk;

    wb_trace_unit #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .flush(flush),
        .RegWrite(RegWrite), .Rd(Rd), .Ra(Ra), .Result(Result), .ResultHi(ResultHi),
        .IsLongMul(IsLongMul), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
        .trace_tag(trace_tag), .trace_data(trace_data), .trace_seq(trace_seq),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [1:0]       kind;
        logic [31:0]      tag;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t q[$];
    int   m_seq;
    bit   m_ovf;
    int   m_drop;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a cycle's records are all kept or all dropped, judged against pre-cycle occupancy.
    task automatic model_step();
        rec_t nw[$];
        rec_t r;
        bit   do_pop;
        if (!reset) begin
            q.delete(); m_seq = 0; m_ovf = 0; m_drop = 0;
            return;
        end
        if (flush) begin
            q.delete();
            return;
        end
        if (trace_en && MemWrite) begin
            r.kind = 2'd1; r.tag = Adr; r.data = WriteData; r.seq = '0; nw.push_back(r);
        end
        if (trace_en && RegWrite) begin
            r.kind = 2'd0; r.tag = {28'd0, Rd}; r.data = Result; r.seq = '0; nw.push_back(r);
            if (IsLongMul) begin
                r.kind = 2'd2; r.tag = {28'd0, Ra}; r.data = ResultHi; nw.push_back(r);
            end
        end
        do_pop = (q.size() != 0) && trace_ready;
        if (nw.size() <= DEPTH - q.size()) begin
            if (do_pop) void'(q.pop_front());
            foreach (nw[i]) begin
                nw[i].seq = SEQ_W'(m_seq);
                m_seq = (m_seq + 1) % (1 << SEQ_W);
                q.push_back(nw[i]);
            end
        end else begin
            if (do_pop) void'(q.pop_front());
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
    endtask

    task automatic check_outputs();
        rec_t h;
        check_val("valid", 64'(trace_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            check_val("kind", 64'(trace_kind), 64'(h.kind));
            check_val("tag",  64'(trace_tag),  64'(h.tag));
            check_val("data", 64'(trace_data), 64'(h.data));
            check_val("seq",  64'(trace_seq),  64'(h.seq));
        end else begin
            check_val("idle_out", 64'({trace_kind, trace_tag, trace_data, trace_seq}), 64'd0);
        end
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        RegWrite = 0; MemWrite = 0; IsLongMul = 0; flush = 0;
    endtask

    task automatic reg_wr(input logic [3:0] rd, input logic [31:0] res);
        idle();
        RegWrite = 1; Rd = rd; Result = res;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        reset = 0; trace_en = 0; flush = 0; RegWrite = 0; IsLongMul = 0; MemWrite = 0;
        trace_ready = 0; Rd = 0; Ra = 0; Result = 0; ResultHi = 0; Adr = 0; WriteData = 0;
        m_seq = 0; m_ovf = 0; m_drop = 0;

        repeat (3) tick();
        reset = 1;
        tick();
        check_val("rst_valid", 64'(trace_valid), 64'd0);
        check_val("rst_seq",   64'(trace_seq),   64'd0);
        check_val("rst_drop",  64'(drop_cnt),    64'd0);

        // Single register write, visible next cycle, then popped.
        trace_en = 1; trace_ready = 1;
        reg_wr(4'd4, 32'h7);
        tick();
        check_val("r4_kind", 64'(trace_kind), 64'd0);
        check_val("r4_tag",  64'(trace_tag),  64'd4);
        check_val("r4_data", 64'(trace_data), 64'd7);
        check_val("r4_seq",  64'(trace_seq),  64'd0);
        idle();
        tick();
        check_val("r4_popped", 64'(trace_valid), 64'd0);

        // Store plus SMULL in one cycle, held back then drained.
        do_reset();
        trace_ready = 0;
        idle();
        MemWrite = 1; Adr = 32'h64; WriteData = 32'hDEADBEEF;
        RegWrite = 1; IsLongMul = 1; Rd = 4'd2; Result = 32'hFFFF_FFFE; Ra = 4'd3; ResultHi = 32'hFFFF_FFFF;
        tick();
        idle();
        repeat (3) tick();
        trace_ready = 1;
        repeat (4) tick();

        // Nearly full FIFO drops a long multiply atomically.
        do_reset();
        trace_ready = 0;
        for (int i = 0; i < 15; i++) begin
            reg_wr(4'(i), 32'(i + 100));
            tick();
        end
        reg_wr(4'd1, 32'hAAAA); IsLongMul = 1; Ra = 4'd9; ResultHi = 32'hBBBB;
        tick();
        check_val("drop_ovf", 64'(overflow), 64'd1);
        check_val("drop_cnt1", 64'(drop_cnt), 64'd1);
        reg_wr(4'd5, 32'h55);
        tick();
        idle();
        trace_ready = 1;
        repeat (17) tick();

        // Reset while full clears everything.
        trace_ready = 0;
        for (int i = 0; i < 16; i++) begin
            reg_wr(4'(i), $urandom);
            tick();
        end
        check_val("full_valid", 64'(trace_valid), 64'd1);
        do_reset();
        check_val("rstfull_valid", 64'(trace_valid), 64'd0);
        check_val("rstfull_ovf",   64'(overflow),    64'd0);

        // Flush with a concurrent write; sequence continues from 5.
        trace_ready = 0;
        for (int i = 0; i < 5; i++) begin
            reg_wr(4'(i), 32'(i));
            tick();
        end
        reg_wr(4'd7, 32'h77);
        flush = 1;
        tick();
        check_val("flush_valid", 64'(trace_valid), 64'd0);
        reg_wr(4'd8, 32'h88);
        tick();
        check_val("flush_seq", 64'(trace_seq), 64'd5);
        idle();
        trace_ready = 1;
        tick();

        // Sequence wrap across 17 back-to-back records.
        do_reset();
        trace_ready = 1;
        for (int i = 0; i < 17; i++) begin
            reg_wr(4'(i), $urandom);
            tick();
        end
        idle();
        tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            reset       = ($urandom_range(0, 149) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            trace_en    = ($urandom_range(0, 9) != 0);
            trace_ready = ($urandom_range(0, 2) == 0);
            RegWrite    = $urandom_range(0, 1) != 0;
            IsLongMul   = $urandom_range(0, 2) == 0;
            MemWrite    = $urandom_range(0, 1) != 0;
            Rd          = 4'($urandom);
            Ra          = 4'($urandom);
            Result      = $urandom;
            ResultHi    = $urandom;
            Adr         = $urandom;
            WriteData   = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
